// File: rtl/snoop_bus_ctrl_pkg.sv
// Shared definitions for the MESI snooping bus: broadcast op encodings used by
// the emitter and receiver cache blocks, the sequencer state encoding, and a
// small index helper for the round-robin pointer.
package snoop_bus_ctrl_pkg;

  typedef logic [1:0] bus_op_t;

  localparam bus_op_t OP_RD_MISS = 2'b00;
  localparam bus_op_t OP_WR_MISS = 2'b01;
  localparam bus_op_t OP_INV     = 2'b10;
  localparam bus_op_t OP_ILLEGAL = 2'b11;

  // Width of a core index on the bus (covers up to 8 cache controllers)
  localparam int SRC_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BCAST = 3'd1,
    ST_SNOOP = 3'd2,
    ST_WB    = 3'd3,
    ST_DONE  = 3'd4
  } snoop_state_t;

  // Only the three real bus operations are broadcast; 11 is rejected
  function automatic logic op_is_legal(input bus_op_t op);
    return op != OP_ILLEGAL;
  endfunction

  // Next index after idx, wrapping at n (used to park the round-robin pointer)
  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] idx,
                                                input int n);
    if (int'(idx) >= n - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/snoop_arb_pick.sv
// Combinational winner select for the snooping bus.
// SNOOP_RR_EN defined  : round-robin search starting at ptr, wrapping at N_CORES.
// SNOOP_RR_EN undefined: fixed priority, lowest index wins (no pointer input).
module snoop_arb_pick
  import snoop_bus_ctrl_pkg::*;
#(
  parameter int N_CORES = 4
) (
  input  logic [N_CORES-1:0] req,
`ifdef SNOOP_RR_EN
  input  logic [SRC_W-1:0]   ptr,
`endif
  output logic [N_CORES-1:0] gnt,
  output logic [SRC_W-1:0]   idx,
  output logic               any
);

`ifdef SNOOP_RR_EN
  int cand;

  // Walk the cores starting at the pointer and take the first requester
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 0; k < N_CORES; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_CORES) begin
        cand = cand - N_CORES;
      end
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = SRC_W'(cand);
      end
    end
  end
`else
  // Scan from the top down so the lowest requesting index is the last to land
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N_CORES - 1; k >= 0; k--) begin
      if (req[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = SRC_W'(k);
        any    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Arbiter and transaction sequencer for the shared MESI snooping bus.
// Grants one cache controller at a time, broadcasts its op for one cycle,
// gathers snoop acks from every other core, runs a memory writeback when a
// Modified line is flushed, and pulses done (with shared/err) to the winner.
// Optional feature: define SNOOP_RR_EN for round-robin arbitration;
// otherwise fixed priority (lowest index wins).
module snoop_bus_ctrl
  import snoop_bus_ctrl_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_CORES-1:0]         req,
  input  logic [2*N_CORES-1:0]       req_op,
  input  logic [ADDR_W*N_CORES-1:0]  req_addr,
  output logic [N_CORES-1:0]         gnt,
  output logic                       bus_valid,
  output logic [1:0]                 bus_op,
  output logic [ADDR_W-1:0]          bus_addr,
  output logic [SRC_W-1:0]           bus_src,
  input  logic [N_CORES-1:0]         snoop_ack,
  input  logic [N_CORES-1:0]         snoop_shared,
  input  logic [N_CORES-1:0]         snoop_wb,
  output logic                       wb_req,
  input  logic                       wb_ack,
  output logic                       done,
  output logic                       done_shared,
  output logic                       err
);

  snoop_state_t state, state_next;

  logic [N_CORES-1:0] pick_gnt;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_any;

  bus_op_t            win_op;
  logic [ADDR_W-1:0]  win_addr;

  logic [N_CORES-1:0] acc_ack, acc_shared, acc_wb;
  logic [N_CORES-1:0] ack_in, ack_next, shared_next, wb_next;
  logic               all_acked;

`ifdef SNOOP_RR_EN
  logic [SRC_W-1:0] rr_ptr;

  snoop_arb_pick #(.N_CORES(N_CORES)) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Park the pointer just past each winner when the bus is handed out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (state == ST_IDLE && pick_any) begin
      rr_ptr <= wrap_inc(pick_idx, N_CORES);
    end
  end
`else
  snoop_arb_pick #(.N_CORES(N_CORES)) u_pick (
    .req (req),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );
`endif

  // Route the winning core's op and address out of the flattened request buses
  always_comb begin
    win_op   = OP_RD_MISS;
    win_addr = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (pick_gnt[i]) begin
        win_op   = req_op[2*i +: 2];
        win_addr = req_addr[ADDR_W*i +: ADDR_W];
      end
    end
  end

  // The registered grant is a one-hot mask of the source; its own snoop
  // response is masked off, and it counts as already acked for the exit test
  assign ack_in      = snoop_ack & ~gnt;
  assign ack_next    = acc_ack | ack_in;
  assign shared_next = acc_shared | (snoop_shared & ack_in);
  assign wb_next     = acc_wb | (snoop_wb & ack_in);
  assign all_acked   = &(ack_next | gnt);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and decoded outputs, all driven from registered state only
  always_comb begin
    state_next  = state;
    bus_valid   = 1'b0;
    wb_req      = 1'b0;
    done        = 1'b0;
    done_shared = 1'b0;
    err         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_next = op_is_legal(win_op) ? ST_BCAST : ST_DONE;
        end
      end
      ST_BCAST: begin
        bus_valid  = 1'b1;
        state_next = ST_SNOOP;
      end
      ST_SNOOP: begin
        if (all_acked) begin
          state_next = (|wb_next) ? ST_WB : ST_DONE;
        end
      end
      ST_WB: begin
        wb_req = 1'b1;
        if (wb_ack) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        done_shared = (bus_op == OP_RD_MISS) && (|acc_shared);
        err         = (bus_op == OP_ILLEGAL);
        state_next  = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Capture the winner's transaction at grant time and drop the grant after done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt      <= '0;
      bus_op   <= OP_RD_MISS;
      bus_addr <= '0;
      bus_src  <= '0;
    end else if (state == ST_IDLE && pick_any) begin
      gnt      <= pick_gnt;
      bus_op   <= win_op;
      bus_addr <= win_addr;
      bus_src  <= pick_idx;
    end else if (state == ST_DONE) begin
      gnt <= '0;
    end
  end

  // Sticky snoop accumulators: cleared on broadcast, OR-collected while snooping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_ack    <= '0;
      acc_shared <= '0;
      acc_wb     <= '0;
    end else if (state == ST_BCAST) begin
      acc_ack    <= '0;
      acc_shared <= '0;
      acc_wb     <= '0;
    end else if (state == ST_SNOOP) begin
      acc_ack    <= ack_next;
      acc_shared <= shared_next;
      acc_wb     <= wb_next;
    end
  end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Self-checking bench for snoop_bus_ctrl: directed scenarios followed by
// randomized request/snoop traffic, checked against a transaction-level model
// of arbitration order, latency, shared/writeback results and error pulses.
module tb_snoop_bus_ctrl;
  import snoop_bus_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int AW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [2*N-1:0]    req_op;
  logic [AW*N-1:0]   req_addr;
  logic [N-1:0]      gnt;
  logic              bus_valid;
  logic [1:0]        bus_op;
  logic [AW-1:0]     bus_addr;
  logic [2:0]        bus_src;
  logic [N-1:0]      snoop_ack, snoop_shared, snoop_wb;
  logic              wb_req, wb_ack, done, done_shared, err;

  always #5 clk = ~clk;

  snoop_bus_ctrl #(.N_CORES(N), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .gnt          (gnt),
    .bus_valid    (bus_valid),
    .bus_op       (bus_op),
    .bus_addr     (bus_addr),
    .bus_src      (bus_src),
    .snoop_ack    (snoop_ack),
    .snoop_shared (snoop_shared),
    .snoop_wb     (snoop_wb),
    .wb_req       (wb_req),
    .wb_ack       (wb_ack),
    .done         (done),
    .done_shared  (done_shared),
    .err          (err)
  );

  int check_count = 0;
  int error_count = 0;

  // Reference model: outstanding requests and arbitration pointer
  logic          pend   [N];
  logic [1:0]    m_op   [N];
  logic [AW-1:0] m_addr [N];
  int            m_ptr;

  // Snooper behaviour for the next transaction
  int   ack_dly [N];
  logic rsp_sh  [N];
  logic rsp_wb  [N];
  int   wb_dly;
  logic src_force;

  int   got_w;
  int   exp_order [4];

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_winner();
    int c;
`ifdef SNOOP_RR_EN
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (pend[c]) return c;
    end
`else
    for (c = 0; c < N; c++) begin
      if (pend[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req[i]               = pend[i];
      req_op[2*i +: 2]     = m_op[i];
      req_addr[AW*i +: AW] = m_addr[i];
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      pend[i]   = 1'b0;
      m_op[i]   = 2'b00;
      m_addr[i] = '0;
    end
    m_ptr = 0;
    drive_reqs();
  endtask

  task automatic applyStimulus(input int core, input logic [1:0] op,
                               input logic [AW-1:0] addr);
    if (!pend[core]) begin
      pend[core]   = 1'b1;
      m_op[core]   = op;
      m_addr[core] = addr;
    end
    drive_reqs();
  endtask

  task automatic quiet_responses();
    for (int i = 0; i < N; i++) begin
      ack_dly[i] = 0;
      rsp_sh[i]  = 1'b0;
      rsp_wb[i]  = 1'b0;
    end
    wb_dly    = 0;
    src_force = 1'b0;
  endtask

  task automatic random_responses();
    for (int i = 0; i < N; i++) begin
      ack_dly[i] = $urandom_range(0, 3);
      rsp_sh[i]  = 1'($urandom_range(0, 1));
      rsp_wb[i]  = ($urandom_range(0, 3) == 0);
    end
    wb_dly    = $urandom_range(0, 2);
    src_force = 1'b0;
  endtask

  task automatic idle_inputs();
    snoop_ack    = '0;
    snoop_shared = '0;
    snoop_wb     = '0;
    wb_ack       = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    clear_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs one transaction from an IDLE negedge; returns at the following IDLE negedge
  task automatic runTxn(input int reset_at, output int winner);
    int w, te, maxd, exp_done, t_done, bv_cnt, err_cnt, wbreq_cnt, exp_wbreq;
    logic exp_sh, exp_wb, legal, got_sh;
    w      = model_winner();
    winner = w;
    if (w < 0) begin
      checkOutput("model_has_request", 0, 1);
      return;
    end
    legal  = (m_op[w] != OP_ILLEGAL);
    maxd   = 0;
    exp_sh = 1'b0;
    exp_wb = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i != w) begin
        if (ack_dly[i] > maxd) maxd = ack_dly[i];
        exp_sh = exp_sh | rsp_sh[i];
        exp_wb = exp_wb | rsp_wb[i];
      end
    end
    if (m_op[w] != OP_RD_MISS) exp_sh = 1'b0;
    te = 1 + maxd;
    if (!legal) begin
      exp_done  = 0;
      exp_wbreq = 0;
    end else if (exp_wb) begin
      exp_done  = te + 2 + wb_dly;
      exp_wbreq = wb_dly + 1;
    end else begin
      exp_done  = te + 1;
      exp_wbreq = 0;
    end
    m_ptr = (w + 1) % N;

    @(negedge clk);
    checkOutput("gnt", 32'(gnt), 32'(1) << w);
    checkOutput("bus_src", 32'(bus_src), 32'(w));
    checkOutput("bus_op", 32'(bus_op), 32'(m_op[w]));
    checkOutput("bus_addr", 32'(bus_addr), 32'(m_addr[w]));

    t_done    = -1;
    got_sh    = 1'b0;
    bv_cnt    = 0;
    err_cnt   = 0;
    wbreq_cnt = 0;
    for (int t = 0; t < 40; t++) begin
      if (t > 0) @(negedge clk);
      if (bus_valid) bv_cnt++;
      if (wb_req)    wbreq_cnt++;
      if (err)       err_cnt++;
      if (t == reset_at) begin
        checkOutput("wb_req_before_reset", 32'(wb_req), 1);
        reset = 1'b1;
        #1;
        checkOutput("rst_gnt", 32'(gnt), 0);
        checkOutput("rst_wb_req", 32'(wb_req), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_bus_valid", 32'(bus_valid), 0);
        idle_inputs();
        clear_model();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checkOutput("post_rst_done", 32'(done), 0);
          checkOutput("post_rst_gnt", 32'(gnt), 0);
        end
        return;
      end
      if (done) begin
        t_done = t;
        got_sh = done_shared;
        break;
      end
      for (int i = 0; i < N; i++) begin
        if (i == w) begin
          snoop_ack[i]    = src_force | 1'($urandom_range(0, 1));
          snoop_shared[i] = src_force | 1'($urandom_range(0, 1));
          snoop_wb[i]     = src_force | 1'($urandom_range(0, 1));
        end else if (t >= 1 && t <= te) begin
          snoop_ack[i]    = (t == 1 + ack_dly[i]);
          snoop_shared[i] = (t == 1 + ack_dly[i]) ? rsp_sh[i] : 1'($urandom_range(0, 1));
          snoop_wb[i]     = (t == 1 + ack_dly[i]) ? rsp_wb[i] : 1'($urandom_range(0, 1));
        end else begin
          snoop_ack[i]    = 1'($urandom_range(0, 1));
          snoop_shared[i] = 1'($urandom_range(0, 1));
          snoop_wb[i]     = 1'($urandom_range(0, 1));
        end
      end
      wb_ack = exp_wb && (t == te + 1 + wb_dly);
      if (t <= te) wb_ack = 1'($urandom_range(0, 1));
    end

    checkOutput("done_latency", 32'(t_done), 32'(exp_done));
    if (t_done >= 0) begin
      checkOutput("done_shared", 32'(got_sh), 32'(exp_sh));
      checkOutput("err_pulses", 32'(err_cnt), legal ? 0 : 1);
      checkOutput("bus_valid_pulses", 32'(bv_cnt), legal ? 1 : 0);
      checkOutput("wb_req_cycles", 32'(wbreq_cnt), 32'(exp_wbreq));
    end
    pend[w] = 1'b0;
    idle_inputs();
    drive_reqs();
    @(negedge clk);
    checkOutput("gnt_after_done", 32'(gnt), 0);
    checkOutput("done_after_done", 32'(done), 0);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    clear_model();
    quiet_responses();
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_gnt", 32'(gnt), 0);
    checkOutput("reset_bus_valid", 32'(bus_valid), 0);
    checkOutput("reset_bus_op", 32'(bus_op), 0);
    checkOutput("reset_bus_addr", 32'(bus_addr), 0);
    checkOutput("reset_bus_src", 32'(bus_src), 0);
    checkOutput("reset_wb_req", 32'(wb_req), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_done_shared", 32'(done_shared), 0);
    checkOutput("reset_err", 32'(err), 0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] read miss core 0 with shared snooper");
    quiet_responses();
    rsp_sh[2] = 1'b1;
    applyStimulus(0, OP_RD_MISS, 16'h0040);
    runTxn(-1, got_w);

    $display("[TB] write miss core 1 with writeback from core 3");
    quiet_responses();
    ack_dly[0] = 2;
    ack_dly[2] = 2;
    rsp_wb[3]  = 1'b1;
    wb_dly     = 2;
    applyStimulus(1, OP_WR_MISS, 16'h1230);
    runTxn(-1, got_w);

    $display("[TB] simultaneous requests from cores 0, 2, 3");
`ifdef SNOOP_RR_EN
    exp_order = '{0, 2, 3, 0};
`else
    exp_order = '{0, 0, 2, 3};
`endif
    do_reset();
    quiet_responses();
    applyStimulus(0, OP_RD_MISS, 16'h0100);
    applyStimulus(2, OP_WR_MISS, 16'h0200);
    applyStimulus(3, OP_INV, 16'h0300);
    runTxn(-1, got_w);
    checkOutput("order_0", 32'(got_w), 32'(exp_order[0]));
    applyStimulus(0, OP_RD_MISS, 16'h0104);
    for (int k = 1; k < 4; k++) begin
      runTxn(-1, got_w);
      checkOutput($sformatf("order_%0d", k), 32'(got_w), 32'(exp_order[k]));
    end

    $display("[TB] illegal op from core 2");
    quiet_responses();
    applyStimulus(2, OP_ILLEGAL, 16'h0bad);
    runTxn(-1, got_w);

    $display("[TB] invalidate from core 1 with its own snoop inputs asserted");
    quiet_responses();
    src_force  = 1'b1;
    ack_dly[0] = 0;
    ack_dly[2] = 1;
    ack_dly[3] = 2;
    for (int i = 0; i < N; i++) rsp_sh[i] = 1'b1;
    applyStimulus(1, OP_INV, 16'h0777);
    runTxn(-1, got_w);

    $display("[TB] reset during writeback, then a normal transaction");
    quiet_responses();
    rsp_wb[3] = 1'b1;
    wb_dly    = 2;
    applyStimulus(0, OP_WR_MISS, 16'h0abc);
    runTxn(2, got_w);
    quiet_responses();
    rsp_sh[3] = 1'b1;
    applyStimulus(1, OP_RD_MISS, 16'h0def);
    runTxn(-1, got_w);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          applyStimulus(i, ($urandom_range(0, 7) == 0) ? OP_ILLEGAL : 2'($urandom_range(0, 2)),
                        AW'($urandom));
        end
      end
      if (model_winner() < 0) begin
        applyStimulus($urandom_range(0, N - 1), 2'($urandom_range(0, 2)), AW'($urandom));
      end
      random_responses();
      runTxn(-1, got_w);
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
